// File: rtl/dice_roller_mux.sv
// Multi-button BCD dice roller: debounced die select, full-rate roll while held,
// frozen result shown on a multiplexed seven-segment display until an inactivity timeout.
module dice_roller_mux #(
  parameter int BTN = 7,
  parameter int DIGITS = 3,
  parameter logic [16*BTN-1:0] SIDES = {16'h0100, 16'h0020, 16'h0012, 16'h0010,
                                        16'h0008, 16'h0006, 16'h0004},
  parameter int PRESCALE_W = 10,
  parameter int DEB_TICKS = 2,
  parameter int TIMEOUT_TICKS = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [BTN-1:0]        btn,
  output logic [6:0]            seg,
  output logic [DIGITS-1:0]     dig_en,
  output logic [4*DIGITS-1:0]   value,
  output logic                  valid
);

  localparam int VW = 4 * DIGITS;
  localparam int SW = (BTN > 1) ? $clog2(BTN) : 1;

  typedef enum logic [1:0] {IDLE, ROLL, SHOW} state_t;

  logic [BTN-1:0]        sync_a, sync_b, db;
  logic [3:0]            deb_cnt [BTN];
  logic [PRESCALE_W-1:0] presc;
  logic                  tick, any, any_q;
  logic [SW-1:0]         pick, sel, sel_n;
  logic [VW-1:0]         side_tab [BTN];
  logic [VW-1:0]         cnt, cnt_n, value_n, hi;
  logic                  valid_n, blank;
  logic [7:0]            tmo, tmo_n;
  state_t                state, state_n;
  logic [1:0]            scan;

  function automatic logic [VW-1:0] bcd_dec(input logic [VW-1:0] x);
    logic [VW-1:0] r;
    logic          borrow;
    r = x;
    borrow = 1'b1;
    for (int d = 0; d < DIGITS; d++) begin
      if (borrow) begin
        if (x[4*d +: 4] == 4'd0) begin
          r[4*d +: 4] = 4'd9;
        end else begin
          r[4*d +: 4] = x[4*d +: 4] - 4'd1;
          borrow = 1'b0;
        end
      end
    end
    return r;
  endfunction

  function automatic logic [6:0] seg_of(input logic [3:0] d);
    case (d)
      4'd0: seg_of = 7'b0111111;
      4'd1: seg_of = 7'b0000110;
      4'd2: seg_of = 7'b1011011;
      4'd3: seg_of = 7'b1001111;
      4'd4: seg_of = 7'b1100110;
      4'd5: seg_of = 7'b1101101;
      4'd6: seg_of = 7'b1111101;
      4'd7: seg_of = 7'b0000111;
      4'd8: seg_of = 7'b1111111;
      4'd9: seg_of = 7'b1101111;
      default: seg_of = 7'b0000000;
    endcase
  endfunction

  assign tick = (presc == '0);
  assign any  = |db;

  always_comb begin
    for (int i = 0; i < BTN; i++) side_tab[i] = SIDES[16*i +: VW];
  end

  always_comb begin
    pick = '0;
    for (int i = BTN - 1; i >= 0; i--) if (db[i]) pick = SW'(i);
  end

  // Debouncers only evaluate on prescaler ticks, so every accepted edge is tick-aligned.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_a <= '0;
      sync_b <= '0;
      db     <= '0;
      presc  <= '0;
      for (int i = 0; i < BTN; i++) deb_cnt[i] <= 4'd0;
    end else begin
      sync_a <= btn;
      sync_b <= sync_a;
      presc  <= presc + 1'b1;
      if (tick) begin
        for (int i = 0; i < BTN; i++) begin
          if (sync_b[i] != db[i]) begin
            if (deb_cnt[i] == 4'(DEB_TICKS - 1)) begin
              db[i]      <= sync_b[i];
              deb_cnt[i] <= 4'd0;
            end else begin
              deb_cnt[i] <= deb_cnt[i] + 4'd1;
            end
          end else begin
            deb_cnt[i] <= 4'd0;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      sel   <= '0;
      cnt   <= '0;
      value <= VW'(1);
      valid <= 1'b0;
      tmo   <= 8'd0;
      any_q <= 1'b0;
    end else begin
      state <= state_n;
      sel   <= sel_n;
      cnt   <= cnt_n;
      value <= value_n;
      valid <= valid_n;
      tmo   <= tmo_n;
      any_q <= any;
    end
  end

  always_comb begin
    state_n = state;
    sel_n   = sel;
    cnt_n   = cnt;
    value_n = value;
    valid_n = valid;
    tmo_n   = tmo;
    case (state)
      ROLL: begin
        if (any) begin
          cnt_n = (cnt == VW'(1)) ? side_tab[sel] : bcd_dec(cnt);
        end else begin
          value_n = cnt;
          valid_n = 1'b1;
          tmo_n   = 8'(TIMEOUT_TICKS);
          state_n = SHOW;
        end
      end
      default: begin
        if (state == SHOW) begin
          if (tick && tmo != 8'd0) tmo_n = tmo - 8'd1;
          if (tmo_n == 8'd0) state_n = IDLE;
        end
        // A fresh press wins over the timeout and abandons SHOW at once.
        if (any && !any_q) begin
          sel_n   = pick;
          cnt_n   = side_tab[pick];
          state_n = ROLL;
        end
      end
    endcase
  end

  always_comb begin
    hi    = value >> {scan, 2'b00};
    blank = (scan != 2'd0) && (hi == '0);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      scan   <= 2'd0;
      seg    <= 7'd0;
      dig_en <= '0;
    end else begin
      scan <= (scan == 2'(DIGITS - 1)) ? 2'd0 : scan + 2'd1;
      if (state == SHOW && !blank) begin
        seg    <= seg_of(value[{scan, 2'b00} +: 4]);
        dig_en <= DIGITS'(1) << scan;
      end else begin
        seg    <= 7'd0;
        dig_en <= '0;
      end
    end
  end

endmodule

// File: tb/tb_dice_roller_mux.sv
// Directed bench for dice_roller_mux with a fast prescaler, two-tick debounce and short timeout.
module tb_dice_roller_mux;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [6:0]  btn;
  logic [6:0]  seg;
  logic [2:0]  dig_en;
  logic [11:0] value;
  logic        valid;

  int checks = 0;
  int failures = 0;

  int cu, ct, ch, junk, first_lit, last_lit;
  logic [6:0] su, st, sh;

  dice_roller_mux #(
    .PRESCALE_W(2),
    .DEB_TICKS(2),
    .TIMEOUT_TICKS(3)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .btn(btn),
    .seg(seg),
    .dig_en(dig_en),
    .value(value),
    .valid(valid)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Records what the display shows over n cycles, sampled mid-cycle.
  task automatic observe(input int n);
    cu = 0; ct = 0; ch = 0; junk = 0; first_lit = -1; last_lit = -1;
    su = 7'd0; st = 7'd0; sh = 7'd0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      case (dig_en)
        3'b000: if (seg != 7'd0) junk++;
        3'b001: begin cu++; su = seg; end
        3'b010: begin ct++; st = seg; end
        3'b100: begin ch++; sh = seg; end
        default: junk++;
      endcase
      if (dig_en != 3'b000) begin
        if (first_lit < 0) first_lit = i;
        last_lit = i;
      end
    end
  endtask

  // Holding the raw button for a multiple of 4 cycles gives exactly h-1 counting cycles.
  task automatic roll(input logic [6:0] b, input int h);
    @(negedge clk);
    btn = b;
    repeat (h) @(negedge clk);
    btn = 7'd0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    btn = 7'd0;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      checks++;
      if ({value, valid, dig_en, seg} !== {12'h001, 1'b0, 3'b000, 7'd0}) begin
        failures++;
        $display("FAIL reset_idle cycle %0d: value=%h valid=%b dig_en=%b seg=%b expected 001/0/000/0000000",
                 i, value, valid, dig_en, seg);
      end
    end
  endtask

  task automatic test_d6;
    roll(7'b0000010, 16);          // N=15 -> 6-3 = 3
    observe(30);
    checks++;
    if (value !== 12'h003) begin failures++; $display("FAIL d6_value: got %h expected 003", value); end
    checks++;
    if (valid !== 1'b1) begin failures++; $display("FAIL d6_valid: got %b expected 1", valid); end
    checks++;
    if (cu == 0) begin failures++; $display("FAIL d6_units_lit: got %0d lit cycles expected >0", cu); end
    checks++;
    if (su !== 7'b1001111) begin failures++; $display("FAIL d6_units_seg: got %b expected 1001111", su); end
    checks++;
    if (ct + ch + junk != 0) begin
      failures++;
      $display("FAIL d6_other_digits: tens=%0d hundreds=%0d bad=%0d expected 0", ct, ch, junk);
    end
  endtask

  task automatic test_d100_wrap;
    roll(7'b1000000, 104);         // N=103 -> wraps once -> 97
    observe(30);
    checks++;
    if (value !== 12'h097) begin failures++; $display("FAIL d100_wrap_value: got %h expected 097", value); end
    checks++;
    if (ct == 0 || st !== 7'b1101111) begin
      failures++; $display("FAIL d100_wrap_tens: lit=%0d seg=%b expected lit>0 seg 1101111", ct, st);
    end
    checks++;
    if (cu == 0 || su !== 7'b0000111) begin
      failures++; $display("FAIL d100_wrap_units: lit=%0d seg=%b expected lit>0 seg 0000111", cu, su);
    end
    checks++;
    if (ch + junk != 0) begin
      failures++; $display("FAIL d100_wrap_blank: hundreds=%0d bad=%0d expected 0", ch, junk);
    end
  endtask

  task automatic test_d100_blank;
    roll(7'b1000000, 96);          // N=95 -> 5
    observe(30);
    checks++;
    if (value !== 12'h005) begin failures++; $display("FAIL d100_blank_value: got %h expected 005", value); end
    checks++;
    if (cu == 0 || su !== 7'b1101101) begin
      failures++; $display("FAIL d100_blank_units: lit=%0d seg=%b expected lit>0 seg 1101101", cu, su);
    end
    checks++;
    if (ct + ch + junk != 0) begin
      failures++; $display("FAIL d100_blank_upper: tens=%0d hundreds=%0d bad=%0d expected 0", ct, ch, junk);
    end
  endtask

  task automatic test_priority_lockout;
    @(negedge clk);
    btn = 7'b0100100;              // d20 and d8 together: d8 wins
    repeat (8) @(negedge clk);
    btn = 7'b1100100;              // d100 joins mid-roll and must be ignored
    repeat (8) @(negedge clk);
    btn = 7'd0;                    // N=15 on d8 -> 8-7 = 1
    observe(30);
    checks++;
    if (value !== 12'h001) begin failures++; $display("FAIL priority_value: got %h expected 001", value); end
    checks++;
    if (value == 12'h000 || value > 12'h008) begin
      failures++; $display("FAIL priority_range: got %h expected 001..008", value);
    end
  endtask

  task automatic test_timeout;
    int span;
    roll(7'b0100000, 8);           // d20, N=7 -> 13
    observe(30);
    span = last_lit - first_lit + 1;
    checks++;
    if (value !== 12'h013) begin failures++; $display("FAIL timeout_value: got %h expected 013", value); end
    checks++;
    if (first_lit < 0 || span < 8 || span > 16) begin
      failures++; $display("FAIL timeout_span: got %0d cycles (first %0d) expected 8..16", span, first_lit);
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if ({dig_en, seg, valid, value} !== {3'b000, 7'd0, 1'b1, 12'h013}) begin
        failures++;
        $display("FAIL timeout_hold: dig_en=%b seg=%b valid=%b value=%h expected 000/0000000/1/013",
                 dig_en, seg, valid, value);
      end
    end
  endtask

  task automatic test_reset_mid_roll;
    @(negedge clk);
    btn = 7'b0000001;
    repeat (14) @(negedge clk);
    rst_n = 1'b0;
    btn = 7'd0;
    @(negedge clk);
    checks++;
    if ({value, valid, dig_en, seg} !== {12'h001, 1'b0, 3'b000, 7'd0}) begin
      failures++;
      $display("FAIL reset_mid_roll: value=%h valid=%b dig_en=%b seg=%b expected 001/0/000/0000000",
               value, valid, dig_en, seg);
    end
    @(negedge clk);
    rst_n = 1'b1;
    observe(30);
    checks++;
    if (valid !== 1'b0 || cu + ct + ch != 0) begin
      failures++; $display("FAIL reset_mid_roll_after: valid=%b lit=%0d expected 0/0", valid, cu + ct + ch);
    end
  endtask

  task automatic test_reset_mid_show;
    bit lit;
    roll(7'b0000010, 8);           // d6, N=7 -> 5
    lit = 1'b0;
    for (int i = 0; i < 20 && !lit; i++) begin
      @(negedge clk);
      if (dig_en != 3'b000) lit = 1'b1;
    end
    checks++;
    if (!lit) begin failures++; $display("FAIL show_lit: display never lit within 20 cycles, expected lit"); end
    checks++;
    if (value !== 12'h005 || valid !== 1'b1) begin
      failures++; $display("FAIL show_value: value=%h valid=%b expected 005/1", value, valid);
    end
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if ({value, valid, dig_en, seg} !== {12'h001, 1'b0, 3'b000, 7'd0}) begin
      failures++;
      $display("FAIL reset_mid_show: value=%h valid=%b dig_en=%b seg=%b expected 001/0/000/0000000",
               value, valid, dig_en, seg);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_bounce;
    roll(7'b0001000, 4);           // one debounce tick at most: must be rejected
    observe(30);
    checks++;
    if (valid !== 1'b0 || value !== 12'h001) begin
      failures++; $display("FAIL bounce_result: valid=%b value=%h expected 0/001", valid, value);
    end
    checks++;
    if (cu + ct + ch + junk != 0) begin
      failures++; $display("FAIL bounce_display: lit=%0d bad=%0d expected 0/0", cu + ct + ch, junk);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    btn = 7'd0;
    test_reset();
    test_d6();
    test_d100_wrap();
    test_d100_blank();
    test_priority_lockout();
    test_timeout();
    test_reset_mid_roll();
    test_reset_mid_show();
    test_bounce();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
